// File: rtl/riscv_core_icache_pkg.sv
// Shared icache definitions: controller state encoding, geometry and address field positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_core_icache_pkg;

  // Geometry: 128 direct-mapped sets of 32-byte blocks, 64-bit addresses
  localparam int IC_ADDR_W   = 64;
  localparam int IC_INDEX_W  = 7;
  localparam int IC_BOFF_W   = 3;
  localparam int IC_TAG_W    = 52;
  localparam int CACHE_DEPTH = 2 ** IC_INDEX_W;
  localparam int BLOCK_BYTES = 32;

  // Address field positions, also used by the data array
  localparam int BOFF_LSB = 2;   // word-in-block [4:2]
  localparam int IDX_LSB  = 5;   // set index     [11:5]
  localparam int TAG_LSB  = 12;  // tag           [63:12]

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_FLUSH  = 2'd3
  } icache_state_e;

endpackage

// File: rtl/riscv_core_icache_tag_array.sv
// Tag + valid storage with two combinational compare ports, one write port, single-cycle flush-all.
// Latency: compare is combinational; writes and flush take effect on the next clock edge.
// Backpressure: none; the controller sequences writes and flushes.
module riscv_core_icache_tag_array
  import riscv_core_icache_pkg::*;
#(
  parameter int INDEX_WIDTH = IC_INDEX_W,
  parameter int TAG_WIDTH   = IC_TAG_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [INDEX_WIDTH-1:0] i_idx0,
  input  logic [TAG_WIDTH-1:0]   i_tag0,
  input  logic [INDEX_WIDTH-1:0] i_idx1,
  input  logic [TAG_WIDTH-1:0]   i_tag1,
  output logic                   o_hit0,
  output logic                   o_hit1,
  input  logic                   i_wr_en,
  input  logic [INDEX_WIDTH-1:0] i_wr_idx,
  input  logic [TAG_WIDTH-1:0]   i_wr_tag,
  input  logic                   i_flush
);

  localparam int DEPTH = 2 ** INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] r_tag [DEPTH];
  logic [DEPTH-1:0]     r_valid;

  // Compare both lookup addresses against their sets
  always_comb begin
    o_hit0 = r_valid[i_idx0] && (r_tag[i_idx0] == i_tag0);
    o_hit1 = r_valid[i_idx1] && (r_tag[i_idx1] == i_tag1);
  end

  // Tag storage carries no reset; a line is only trusted through its valid bit
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_tag[i_wr_idx] <= i_wr_tag;
  end

  // Valid bits: cleared by reset or flush, set by a refill write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_valid <= '0;
    else if (i_flush) r_valid <= '0;
    else if (i_wr_en) r_valid[i_wr_idx] <= 1'b1;
  end

endmodule

// File: rtl/riscv_core_icache_controller.sv
// Icache control: hit detection for possibly block-straddling fetches, miss/refill FSM, data-array strobes.
// Latency: hits are zero-cycle (combinational); a miss costs LOOKUP + REQ + WAIT cycles per missing block.
// Backpressure: o_stall holds the core while refilling/flushing; o_axi_req is held until i_axi_ready.
module riscv_core_icache_controller
  import riscv_core_icache_pkg::*;
#(
  parameter int ADDR_WIDTH         = IC_ADDR_W,
  parameter int INDEX_WIDTH        = IC_INDEX_W,
  parameter int BLOCK_OFFSET_WIDTH = IC_BOFF_W,
  parameter int TAG_WIDTH          = IC_TAG_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr_from_core,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_rd_en,
  output logic                  o_wr_en,
  output logic                  o_block_replace,
  output logic                  o_offset,
  output logic                  o_axi_req,
  output logic [ADDR_WIDTH-1:0] o_axi_addr,
  input  logic                  i_axi_ready,
  input  logic                  i_axi_rvalid
);

  icache_state_e r_state, w_next_state;
  logic          r_miss_sel;
  logic          r_flush_pending;

  logic [ADDR_WIDTH-1:0] w_a0, w_a1, w_sel;
  logic w_cross, w_hit0, w_hit1, w_hit;
  logic w_capture, w_tag_wr, w_tag_flush;
  logic w_unused;

  // Address arithmetic: second halfword may fall in the next block (carry into index/tag allowed)
  always_comb begin
    w_a0     = i_addr_from_core;
    w_a1     = i_addr_from_core + ADDR_WIDTH'(2);
    w_cross  = (w_a0[IDX_LSB-1:1] == '1);
    w_hit    = w_hit0 && (!w_cross || w_hit1);
    w_sel    = r_miss_sel ? w_a1 : w_a0;
    o_axi_addr = {w_sel[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
    w_unused = ^{w_a0[0], w_a1[IDX_LSB-1:0], w_sel[IDX_LSB-1:0]};
  end

  riscv_core_icache_tag_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_tag_array (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_idx0   (w_a0[IDX_LSB +: INDEX_WIDTH]),
    .i_tag0   (w_a0[ADDR_WIDTH-1 -: TAG_WIDTH]),
    .i_idx1   (w_a1[IDX_LSB +: INDEX_WIDTH]),
    .i_tag1   (w_a1[ADDR_WIDTH-1 -: TAG_WIDTH]),
    .o_hit0   (w_hit0),
    .o_hit1   (w_hit1),
    .i_wr_en  (w_tag_wr),
    .i_wr_idx (w_sel[IDX_LSB +: INDEX_WIDTH]),
    .i_wr_tag (w_sel[ADDR_WIDTH-1 -: TAG_WIDTH]),
    .i_flush  (w_tag_flush)
  );

  // Next-state and output decode
  always_comb begin
    w_next_state    = r_state;
    o_stall         = 1'b0;
    o_rd_en         = 1'b0;
    o_wr_en         = 1'b0;
    o_block_replace = 1'b0;
    o_offset        = 1'b0;
    o_axi_req       = 1'b0;
    w_capture       = 1'b0;
    w_tag_wr        = 1'b0;
    w_tag_flush     = 1'b0;
    case (r_state)
      S_LOOKUP: begin
        if (i_flush || r_flush_pending) begin
          // No fetch is served on the cycle that commits to a flush
          o_stall      = i_req;
          w_next_state = S_FLUSH;
        end else if (i_req) begin
          if (w_hit) begin
            o_rd_en = 1'b1;
          end else begin
            o_stall      = 1'b1;
            w_capture    = 1'b1;
            w_next_state = S_REQ;
          end
        end
      end
      S_REQ: begin
        o_stall   = 1'b1;
        o_axi_req = 1'b1;
        if (i_axi_ready) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (i_axi_rvalid) begin
          o_wr_en         = 1'b1;
          o_block_replace = 1'b1;
          o_offset        = r_miss_sel;
          w_tag_wr        = 1'b1;
          w_next_state    = S_LOOKUP;
        end
      end
      S_FLUSH: begin
        o_stall      = 1'b1;
        w_tag_flush  = 1'b1;
        w_next_state = S_LOOKUP;
      end
      default: w_next_state = S_LOOKUP;
    endcase
  end

  // State register, miss block select and deferred-flush latch
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_LOOKUP;
      r_miss_sel      <= 1'b0;
      r_flush_pending <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // First block present means only the second block is missing
      if (w_capture) r_miss_sel <= w_hit0;
      if (r_state == S_FLUSH)
        r_flush_pending <= 1'b0;
      else if (i_flush && (r_state == S_REQ || r_state == S_WAIT))
        r_flush_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_core_icache_controller.sv
// Directed bench for the icache controller: refills, hits, crossing fetches, conflicts, flush and reset.
// Latency: inputs change 1 ns after a rising edge, outputs are checked at the falling edge.
// Backpressure: the bench plays the AXI master, granting ready one cycle late and rvalid three cycles later.
module tb_riscv_core_icache_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [63:0] addr;
  logic        flush;
  logic        stall, rd_en, wr_en, block_replace, offset, axi_req;
  logic [63:0] axi_addr;
  logic        axi_ready, axi_rvalid;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  riscv_core_icache_controller dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_req            (req),
    .i_addr_from_core (addr),
    .i_flush          (flush),
    .o_stall          (stall),
    .o_rd_en          (rd_en),
    .o_wr_en          (wr_en),
    .o_block_replace  (block_replace),
    .o_offset         (offset),
    .o_axi_req        (axi_req),
    .o_axi_addr       (axi_addr),
    .i_axi_ready      (axi_ready),
    .i_axi_rvalid     (axi_rvalid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after an edge with a missing fetch presented; walks LOOKUP-miss, REQ, WAIT and
  // returns 1 ns after the edge that writes the block (controller back in LOOKUP).
  task automatic refill(input logic [63:0] blk, input logic exp_off, input bit flush_in_wait);
    #4;
    chk("miss_stall", {63'd0, stall}, 64'd1);
    chk("miss_rd_en", {63'd0, rd_en}, 64'd0);
    step();
    #4;
    chk("req_axi_req", {63'd0, axi_req}, 64'd1);
    chk("req_axi_addr", axi_addr, blk);
    chk("req_stall", {63'd0, stall}, 64'd1);
    step();
    axi_ready = 1'b1;
    #4;
    chk("req_hold", {63'd0, axi_req}, 64'd1);
    step();
    axi_ready = 1'b0;
    if (flush_in_wait) flush = 1'b1;
    #4;
    chk("wait_axi_req", {63'd0, axi_req}, 64'd0);
    chk("wait_wr_en", {63'd0, wr_en}, 64'd0);
    step();
    flush = 1'b0;
    #4;
    chk("wait_stall", {63'd0, stall}, 64'd1);
    step();
    axi_rvalid = 1'b1;
    #4;
    chk("fill_wr_en", {63'd0, wr_en}, 64'd1);
    chk("fill_replace", {63'd0, block_replace}, 64'd1);
    chk("fill_offset", {63'd0, offset}, {63'd0, exp_off});
    chk("fill_rd_en", {63'd0, rd_en}, 64'd0);
    step();
    axi_rvalid = 1'b0;
  endtask

  task automatic expect_hit(input string tag);
    #4;
    chk({tag, "_rd_en"}, {63'd0, rd_en}, 64'd1);
    chk({tag, "_stall"}, {63'd0, stall}, 64'd0);
    chk({tag, "_axi_req"}, {63'd0, axi_req}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = 64'd0; flush = 1'b0;
    axi_ready = 1'b0; axi_rvalid = 1'b0;
    #2;
    chk("rst_stall_idle", {63'd0, stall}, 64'd0);
    chk("rst_axi_req", {63'd0, axi_req}, 64'd0);
    chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    req = 1'b1; addr = 64'h1000;
    #1;
    chk("rst_stall_req", {63'd0, stall}, 64'd1);
    step();
    rst_n = 1'b1;

    // Cold miss on 0x1000, then hit
    refill(64'h1000, 1'b0, 1'b0);
    expect_hit("hit_1000");

    // Further words of the cached block hit back to back
    step(); addr = 64'h1004; expect_hit("hit_1004");
    step(); addr = 64'h101C; expect_hit("hit_101C");

    // Crossing fetch, only the second block missing
    step(); addr = 64'h101E;
    refill(64'h1020, 1'b1, 1'b0);
    expect_hit("hit_101E");

    // Crossing fetch, both blocks missing: two refills in sequence
    step(); addr = 64'h203E;
    refill(64'h2020, 1'b0, 1'b0);
    refill(64'h2040, 1'b1, 1'b0);
    expect_hit("hit_203E");

    // Conflict on set 0: 0x2000 evicts 0x1000
    step(); addr = 64'h2000;
    refill(64'h2000, 1'b0, 1'b0);
    expect_hit("hit_2000");
    step(); addr = 64'h1000;
    refill(64'h1000, 1'b0, 1'b0);
    expect_hit("hit_1000_again");

    // Flush raised during WAIT: fill completes, one flush cycle, then the same address misses
    step(); addr = 64'h3040;
    refill(64'h3040, 1'b0, 1'b1);
    #4;
    chk("pend_stall", {63'd0, stall}, 64'd1);
    chk("pend_rd_en", {63'd0, rd_en}, 64'd0);
    step();
    #4;
    chk("flush_stall", {63'd0, stall}, 64'd1);
    chk("flush_rd_en", {63'd0, rd_en}, 64'd0);
    step();
    refill(64'h3040, 1'b0, 1'b0);
    expect_hit("hit_3040");

    // Re-cache 0x1000, then reset during a refill of another block
    step(); addr = 64'h1000;
    refill(64'h1000, 1'b0, 1'b0);
    expect_hit("hit_1000_pre_rst");
    step(); addr = 64'h4020;
    #4;
    chk("rstmid_miss", {63'd0, stall}, 64'd1);
    step();
    axi_ready = 1'b1;
    #4;
    chk("rstmid_axi_req", {63'd0, axi_req}, 64'd1);
    step();
    axi_ready = 1'b0;
    axi_rvalid = 1'b1;
    #4;
    chk("rstmid_wr_pre", {63'd0, wr_en}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rstmid_axi_off", {63'd0, axi_req}, 64'd0);
    chk("rstmid_replace", {63'd0, block_replace}, 64'd0);
    chk("rstmid_stall", {63'd0, stall}, 64'd1);
    step();
    axi_rvalid = 1'b0;
    rst_n = 1'b1;
    addr = 64'h1000;
    refill(64'h1000, 1'b0, 1'b0);
    expect_hit("hit_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
